local_net_iface: RTL and testbench
==================================

# local_net_iface

Network interface between a processing element and a mesh router's local (L) port. Packs core messages into single-flit 16-bit packets and injects them into the router's local input buffer under credit flow control. Ejects flits from the router's local output port into a receive FIFO for the core, returning one credit to the router per flit the core consumes.

## Interface
- XCOORD, 4'd0: this node's X coordinate; compared against flit[7:4].
- YCOORD, 4'd0: this node's Y coordinate; compared against flit[3:0].
- NET_CREDITS, 4: depth of the router's local input buffer; initial injection credit count.
- TX_DEPTH, 4: transmit queue depth in flits (power of 2, ≥2).
- RX_DEPTH, 4: receive FIFO depth in flits (power of 2, ≥2). The router's local output port credit count must be initialised to RX_DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- tx_valid_i  in  1  core offers a message.
- tx_ready_o  out  1  transmit queue can accept; equals !tx_full.
- tx_dest_i  in  8  destination, {x[3:0], y[3:0]}.
- tx_payload_i  in  8  message payload.
- rx_valid_o  out  1  receive FIFO non-empty.
- rx_ready_i  in  1  core pops the receive head.
- rx_data_o  out  16  receive FIFO head (show-ahead).
- net_data_o  out  16  flit to router local input: {payload, dest}.
- net_valid_o  out  1  flit valid; one-cycle pulse per flit.
- net_credit_i  in  1  router freed one local input slot.
- net_data_i  in  16  flit from router local output.
- net_enable_i  in  1  net_data_i valid this cycle.
- net_credit_o  out  1  one-cycle pulse returning one credit to the router.
- misroute_o  out  1  sticky: a received flit's dest is not {XCOORD, YCOORD}.
- rx_overflow_o  out  1  sticky: a flit arrived and was dropped because the receive FIFO was full.
- credit_err_o  out  1  sticky: net_credit_i arrived with the counter already at NET_CREDITS.

## Operation
- Transmit push: on tx_valid_i && tx_ready_o, write {tx_payload_i, tx_dest_i} to the tail of the TX queue.
- Credit counter: width $clog2(NET_CREDITS+1); resets to NET_CREDITS.
- Inject: each cycle with TX non-empty and credit > 0:
  - register the head onto net_data_o;
  - pulse net_valid_o;
  - pop the head;
  - decrement credit.
  Otherwise net_valid_o = 0, and net_data_o holds its last value.
- Credit update: net_credit_i increments the counter.
  - Injection and net_credit_i in the same cycle leave the count unchanged.
  - net_credit_i at NET_CREDITS (with no injection that cycle) is ignored and sets credit_err_o.
- Receive write: on net_enable_i, write net_data_i to the RX FIFO if it is not full, or if a pop occurs in the same cycle. Otherwise drop the flit and set rx_overflow_o.
- Destination check: any flit with net_data_i[7:0] != {XCOORD, YCOORD} and net_enable_i high sets misroute_o. The flit is still buffered if space allows.
- Receive pop: rx_valid_o && rx_ready_i pops the head. net_credit_o is registered high for exactly the following cycle, once per pop.
- Sticky flags clear only on reset.
- Pointers are wrap-around binary counters with an extra bit for full/empty disambiguation.

## Timing
- Reset (asynchronous) values:
  - net_valid_o = 0, net_data_o = 0, net_credit_o = 0;
  - all sticky flags = 0;
  - TX and RX queues empty, so tx_ready_o = 1 and rx_valid_o = 0;
  - credit = NET_CREDITS.
- Reset asserted mid-transfer discards all queued flits. No credit pulse is emitted for discarded RX flits.
- Injection latency: a message accepted at edge t appears on net_valid_o after edge t+1 when credit is available. Sustained throughput is 1 flit/cycle.
- tx_ready_o deasserts in the cycle after the push that fills the queue. It reasserts in the cycle after the first injection from a full queue.
- Ejection latency: a flit written at edge t is visible on rx_valid_o/rx_data_o after edge t.
- Credit return: a pop at edge t pulses net_credit_o during cycle t→t+1. Back-to-back pops give back-to-back pulses.
- Credit stall: at credit 0, net_valid_o stays 0. Injection resumes at the edge after net_credit_i is sampled.

## Test plan
- Basic inject:
  - Stimulus: after reset, push dest 8'h21, payload 8'hA5.
  - Required: net_valid_o for exactly one cycle with net_data_o = 16'hA521 at edge t+1; credit = 3.
- Credit exhaustion:
  - Stimulus: NET_CREDITS=4, push 6 messages, net_credit_i held 0.
  - Required: exactly 4 flits sent on consecutive cycles, then stall. Each single net_credit_i pulse releases exactly one more flit.
- TX full:
  - Stimulus: credit held at 0, push 5 messages.
  - Required: tx_ready_o = 0 after the 4th push; the 5th is not accepted.
- Eject and credit return:
  - Stimulus: XCOORD=1, YCOORD=2; drive flit 16'h3C12, then pop with rx_ready_i.
  - Required: rx_data_o = 16'h3C12; a single net_credit_o pulse the cycle after the pop; misroute_o stays 0.
- Errors:
  - Stimulus: write 5 flits with no pops (RX_DEPTH=4), including one to dest 8'h00. Pulse net_credit_i at full credit.
  - Required: rx_overflow_o = 1, misroute_o = 1, credit_err_o = 1. Exactly 4 flits remain buffered.
- Simultaneous events and reset:
  - Stimulus: inject and net_credit_i in the same cycle; then assert rst mid-stream.
  - Required: the credit count is unchanged by the simultaneous events. On reset, all outputs return to their reset values immediately (asynchronously).

Source files
------------

// File: rtl/local_net_iface.sv
// rtl/local_net_iface.sv - credit-flow-controlled network interface for a mesh router local port
`timescale 1ns/1ps
module local_net_iface #(
  parameter int XCOORD      = 0,
  parameter int YCOORD      = 0,
  parameter int NET_CREDITS = 4,
  parameter int TX_DEPTH    = 4,
  parameter int RX_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [7:0]  tx_dest_i,
  input  logic [7:0]  tx_payload_i,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [15:0] rx_data_o,
  output logic [15:0] net_data_o,
  output logic        net_valid_o,
  input  logic        net_credit_i,
  input  logic [15:0] net_data_i,
  input  logic        net_enable_i,
  output logic        net_credit_o,
  output logic        misroute_o,
  output logic        rx_overflow_o,
  output logic        credit_err_o
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int CW  = $clog2(NET_CREDITS + 1);
  localparam logic [7:0]    MY_ADDR  = {4'(XCOORD), 4'(YCOORD)};
  localparam logic [CW-1:0] CRED_MAX = CW'(NET_CREDITS);

  logic [15:0]   tx_mem [TX_DEPTH];
  logic [15:0]   rx_mem [RX_DEPTH];
  logic [TAW:0]  tx_wr_q, tx_rd_q;
  logic [RAW:0]  rx_wr_q, rx_rd_q;
  logic [CW-1:0] credit_q, credit_d;
  logic          credit_err_q, credit_err_d;
  logic [15:0]   net_data_q;
  logic          net_valid_q, net_credit_q, misroute_q, rx_overflow_q;

  logic tx_empty, tx_full, tx_push, inject;
  logic rx_empty, rx_full, rx_pop, rx_write, rx_drop;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[TAW] != tx_rd_q[TAW]) && (tx_wr_q[TAW-1:0] == tx_rd_q[TAW-1:0]);
  assign tx_push  = tx_valid_i && !tx_full;
  assign inject   = !tx_empty && (credit_q != '0);

  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[RAW] != rx_rd_q[RAW]) && (rx_wr_q[RAW-1:0] == rx_rd_q[RAW-1:0]);
  assign rx_pop   = !rx_empty && rx_ready_i;
  // A pop in the same cycle frees the slot the incoming flit needs.
  assign rx_write = net_enable_i && (!rx_full || rx_pop);
  assign rx_drop  = net_enable_i && rx_full && !rx_pop;

  always_comb begin
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    if (inject && !net_credit_i) begin
      credit_d = credit_q - 1'b1;
    end else if (!inject && net_credit_i) begin
      if (credit_q == CRED_MAX) credit_err_d = 1'b1;
      else                      credit_d     = credit_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push)  tx_mem[tx_wr_q[TAW-1:0]] <= {tx_payload_i, tx_dest_i};
    if (rx_write) rx_mem[rx_wr_q[RAW-1:0]] <= net_data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr_q       <= '0;
      tx_rd_q       <= '0;
      rx_wr_q       <= '0;
      rx_rd_q       <= '0;
      credit_q      <= CRED_MAX;
      credit_err_q  <= 1'b0;
      net_data_q    <= '0;
      net_valid_q   <= 1'b0;
      net_credit_q  <= 1'b0;
      misroute_q    <= 1'b0;
      rx_overflow_q <= 1'b0;
    end else begin
      if (tx_push)  tx_wr_q <= tx_wr_q + 1'b1;
      if (inject) begin
        tx_rd_q    <= tx_rd_q + 1'b1;
        net_data_q <= tx_mem[tx_rd_q[TAW-1:0]];
      end
      net_valid_q  <= inject;
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
      if (rx_write) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)   rx_rd_q <= rx_rd_q + 1'b1;
      net_credit_q <= rx_pop;
      if (net_enable_i && (net_data_i[7:0] != MY_ADDR)) misroute_q <= 1'b1;
      if (rx_drop) rx_overflow_q <= 1'b1;
    end
  end

  assign tx_ready_o    = !tx_full;
  assign rx_valid_o    = !rx_empty;
  assign rx_data_o     = rx_mem[rx_rd_q[RAW-1:0]];
  assign net_data_o    = net_data_q;
  assign net_valid_o   = net_valid_q;
  assign net_credit_o  = net_credit_q;
  assign misroute_o    = misroute_q;
  assign rx_overflow_o = rx_overflow_q;
  assign credit_err_o  = credit_err_q;

endmodule

// File: tb/tb_local_net_iface.sv
// tb/tb_local_net_iface.sv - directed self-checking bench for local_net_iface
`timescale 1ns/1ps
module tb_local_net_iface;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_valid_i, tx_ready_o;
  logic [7:0]  tx_dest_i, tx_payload_i;
  logic        rx_valid_o, rx_ready_i;
  logic [15:0] rx_data_o, net_data_o, net_data_i;
  logic        net_valid_o, net_credit_i, net_enable_i, net_credit_o;
  logic        misroute_o, rx_overflow_o, credit_err_o;

  int checks = 0;
  int failures = 0;
  logic [15:0] seen [$];

  always #5 clk = ~clk;

  local_net_iface #(
    .XCOORD(1), .YCOORD(2), .NET_CREDITS(4), .TX_DEPTH(4), .RX_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .tx_dest_i(tx_dest_i), .tx_payload_i(tx_payload_i),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o),
    .net_data_o(net_data_o), .net_valid_o(net_valid_o),
    .net_credit_i(net_credit_i), .net_data_i(net_data_i),
    .net_enable_i(net_enable_i), .net_credit_o(net_credit_o),
    .misroute_o(misroute_o), .rx_overflow_o(rx_overflow_o),
    .credit_err_o(credit_err_o)
  );

  // Advance one edge, sample 1ns later and log any injected flit.
  task automatic tick();
    @(posedge clk);
    #1;
    if (net_valid_o) seen.push_back(net_data_o);
  endtask

  task automatic test_reset();
    rst = 1'b0; tx_valid_i = 0; tx_dest_i = 0; tx_payload_i = 0;
    rx_ready_i = 0; net_credit_i = 0; net_data_i = 0; net_enable_i = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tx_ready_o !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got %b want 1", tx_ready_o); end
    checks++; if (rx_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got %b want 0", rx_valid_o); end
    checks++; if (net_valid_o !== 1'b0) begin failures++; $display("FAIL reset_net_valid got %b want 0", net_valid_o); end
    checks++; if (net_data_o !== 16'h0) begin failures++; $display("FAIL reset_net_data got %h want 0000", net_data_o); end
    checks++; if (net_credit_o !== 1'b0) begin failures++; $display("FAIL reset_net_credit got %b want 0", net_credit_o); end
    checks++; if ({misroute_o, rx_overflow_o, credit_err_o} !== 3'b000) begin failures++; $display("FAIL reset_flags got %b want 000", {misroute_o, rx_overflow_o, credit_err_o}); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_inject();
    seen.delete();
    tx_valid_i = 1; tx_dest_i = 8'h21; tx_payload_i = 8'hA5;
    tick();
    tx_valid_i = 0;
    checks++; if (net_valid_o !== 1'b0) begin failures++; $display("FAIL inj_early got %b want 0", net_valid_o); end
    tick();
    checks++; if (net_valid_o !== 1'b1) begin failures++; $display("FAIL inj_valid got %b want 1", net_valid_o); end
    checks++; if (net_data_o !== 16'hA521) begin failures++; $display("FAIL inj_data got %h want a521", net_data_o); end
    tick();
    checks++; if (net_valid_o !== 1'b0) begin failures++; $display("FAIL inj_pulse got %b want 0", net_valid_o); end
    checks++; if (net_data_o !== 16'hA521) begin failures++; $display("FAIL inj_hold got %h want a521", net_data_o); end
    net_credit_i = 1;
    tick();
    net_credit_i = 0;
    checks++; if (credit_err_o !== 1'b0) begin failures++; $display("FAIL inj_credit3 got %b want 0", credit_err_o); end
    checks++; if (seen.size() !== 1) begin failures++; $display("FAIL inj_count got %0d want 1", seen.size()); end
  endtask

  task automatic test_credit_exhaust();
    logic [15:0] exp;
    seen.delete();
    for (int i = 0; i < 6; i++) begin
      tx_valid_i = 1; tx_dest_i = 8'h10 + 8'(i); tx_payload_i = 8'hB0 + 8'(i);
      tick();
      checks++; if (net_valid_o !== (i >= 1 && i <= 4)) begin failures++; $display("FAIL exh_valid_%0d got %b want %b", i, net_valid_o, (i >= 1 && i <= 4)); end
    end
    tx_valid_i = 0;
    repeat (3) tick();
    checks++; if (seen.size() !== 4) begin failures++; $display("FAIL exh_count got %0d want 4", seen.size()); end
    for (int k = 0; k < 4 && k < seen.size(); k++) begin
      exp = {8'hB0 + 8'(k), 8'h10 + 8'(k)};
      checks++; if (seen[k] !== exp) begin failures++; $display("FAIL exh_data_%0d got %h want %h", k, seen[k], exp); end
    end
    for (int r = 0; r < 2; r++) begin
      net_credit_i = 1;
      tick();
      net_credit_i = 0;
      checks++; if (net_valid_o !== 1'b0) begin failures++; $display("FAIL exh_rel_early_%0d got %b want 0", r, net_valid_o); end
      tick();
      exp = {8'hB4 + 8'(r), 8'h14 + 8'(r)};
      checks++; if (net_valid_o !== 1'b1) begin failures++; $display("FAIL exh_rel_valid_%0d got %b want 1", r, net_valid_o); end
      checks++; if (net_data_o !== exp) begin failures++; $display("FAIL exh_rel_data_%0d got %h want %h", r, net_data_o, exp); end
      tick();
      checks++; if (net_valid_o !== 1'b0) begin failures++; $display("FAIL exh_rel_once_%0d got %b want 0", r, net_valid_o); end
    end
  endtask

  task automatic test_tx_full();
    logic [15:0] exp;
    seen.delete();
    for (int i = 0; i < 5; i++) begin
      tx_valid_i = 1; tx_dest_i = 8'h40 + 8'(i); tx_payload_i = 8'hC0 + 8'(i);
      checks++; if (tx_ready_o !== (i < 4)) begin failures++; $display("FAIL full_ready_%0d got %b want %b", i, tx_ready_o, (i < 4)); end
      tick();
    end
    tx_valid_i = 0;
    checks++; if (tx_ready_o !== 1'b0) begin failures++; $display("FAIL full_after got %b want 0", tx_ready_o); end
    net_credit_i = 1;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (j == 1) begin
        checks++; if (tx_ready_o !== 1'b1) begin failures++; $display("FAIL full_reassert got %b want 1", tx_ready_o); end
      end
    end
    net_credit_i = 0;
    repeat (4) tick();
    checks++; if (seen.size() !== 4) begin failures++; $display("FAIL full_count got %0d want 4", seen.size()); end
    for (int k = 0; k < 4 && k < seen.size(); k++) begin
      exp = {8'hC0 + 8'(k), 8'h40 + 8'(k)};
      checks++; if (seen[k] !== exp) begin failures++; $display("FAIL full_data_%0d got %h want %h", k, seen[k], exp); end
    end
    net_credit_i = 1;
    repeat (4) tick();
    net_credit_i = 0;
    checks++; if (credit_err_o !== 1'b0) begin failures++; $display("FAIL full_restore got %b want 0", credit_err_o); end
  endtask

  task automatic test_eject();
    net_enable_i = 1; net_data_i = 16'h3C12;
    tick();
    net_enable_i = 0;
    checks++; if (rx_valid_o !== 1'b1) begin failures++; $display("FAIL ej_valid got %b want 1", rx_valid_o); end
    checks++; if (rx_data_o !== 16'h3C12) begin failures++; $display("FAIL ej_data got %h want 3c12", rx_data_o); end
    checks++; if (net_credit_o !== 1'b0) begin failures++; $display("FAIL ej_no_credit got %b want 0", net_credit_o); end
    rx_ready_i = 1;
    tick();
    rx_ready_i = 0;
    checks++; if (net_credit_o !== 1'b1) begin failures++; $display("FAIL ej_credit got %b want 1", net_credit_o); end
    checks++; if (rx_valid_o !== 1'b0) begin failures++; $display("FAIL ej_empty got %b want 0", rx_valid_o); end
    tick();
    checks++; if (net_credit_o !== 1'b0) begin failures++; $display("FAIL ej_credit_once got %b want 0", net_credit_o); end
    checks++; if (misroute_o !== 1'b0) begin failures++; $display("FAIL ej_misroute got %b want 0", misroute_o); end
  endtask

  task automatic test_simultaneous();
    seen.delete();
    tx_valid_i = 1; tx_dest_i = 8'h55; tx_payload_i = 8'h01;
    tick();
    tx_valid_i = 0; net_credit_i = 1;
    tick();
    net_credit_i = 0;
    checks++; if (net_data_o !== 16'h0155 || net_valid_o !== 1'b1) begin failures++; $display("FAIL sim_inject got %b/%h want 1/0155", net_valid_o, net_data_o); end
    checks++; if (credit_err_o !== 1'b0) begin failures++; $display("FAIL sim_no_err got %b want 0", credit_err_o); end
    seen.delete();
    for (int i = 0; i < 5; i++) begin
      tx_valid_i = 1; tx_dest_i = 8'h70 + 8'(i); tx_payload_i = 8'h60 + 8'(i);
      tick();
    end
    tx_valid_i = 0;
    repeat (3) tick();
    checks++; if (seen.size() !== 4) begin failures++; $display("FAIL sim_count got %0d want 4", seen.size()); end
    net_credit_i = 1;
    repeat (5) tick();
    net_credit_i = 0;
    tick();
    checks++; if (seen.size() !== 5) begin failures++; $display("FAIL sim_last_count got %0d want 5", seen.size()); end
    if (seen.size() == 5) begin
      checks++; if (seen[4] !== 16'h6474) begin failures++; $display("FAIL sim_last_data got %h want 6474", seen[4]); end
    end
    checks++; if (credit_err_o !== 1'b0) begin failures++; $display("FAIL sim_restore got %b want 0", credit_err_o); end
  endtask

  task automatic test_errors();
    logic [15:0] flits [5];
    flits = '{16'h0112, 16'h0212, 16'h0300, 16'h0412, 16'h0512};
    for (int i = 0; i < 5; i++) begin
      net_enable_i = 1; net_data_i = flits[i];
      tick();
      if (i == 3) begin
        checks++; if (rx_overflow_o !== 1'b0) begin failures++; $display("FAIL err_ovf_early got %b want 0", rx_overflow_o); end
      end
    end
    net_enable_i = 0;
    checks++; if (rx_overflow_o !== 1'b1) begin failures++; $display("FAIL err_overflow got %b want 1", rx_overflow_o); end
    checks++; if (misroute_o !== 1'b1) begin failures++; $display("FAIL err_misroute got %b want 1", misroute_o); end
    net_credit_i = 1;
    tick();
    net_credit_i = 0;
    checks++; if (credit_err_o !== 1'b1) begin failures++; $display("FAIL err_credit got %b want 1", credit_err_o); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_valid_o !== 1'b1 || rx_data_o !== flits[i]) begin failures++; $display("FAIL err_pop_%0d got %b/%h want 1/%h", i, rx_valid_o, rx_data_o, flits[i]); end
      rx_ready_i = 1;
      tick();
      checks++; if (net_credit_o !== 1'b1) begin failures++; $display("FAIL err_credit_pulse_%0d got %b want 1", i, net_credit_o); end
    end
    rx_ready_i = 0;
    checks++; if (rx_valid_o !== 1'b0) begin failures++; $display("FAIL err_drained got %b want 0", rx_valid_o); end
    tick();
    checks++; if (net_credit_o !== 1'b0) begin failures++; $display("FAIL err_credit_end got %b want 0", net_credit_o); end
  endtask

  task automatic test_reset_mid();
    tx_valid_i = 1; tx_dest_i = 8'h12; tx_payload_i = 8'hAA;
    net_enable_i = 1; net_data_i = 16'h7712;
    tick();
    tx_payload_i = 8'hAB; net_data_i = 16'h7812;
    tick();
    tx_payload_i = 8'hAC; net_enable_i = 0; rx_ready_i = 1;
    tick();
    tx_valid_i = 0; rx_ready_i = 0;
    checks++; if (net_valid_o !== 1'b1 || net_credit_o !== 1'b1) begin failures++; $display("FAIL mid_pre got %b%b want 11", net_valid_o, net_credit_o); end
    #2 rst = 1'b0;
    #1;
    checks++; if (net_valid_o !== 1'b0) begin failures++; $display("FAIL mid_net_valid got %b want 0", net_valid_o); end
    checks++; if (net_data_o !== 16'h0) begin failures++; $display("FAIL mid_net_data got %h want 0000", net_data_o); end
    checks++; if (net_credit_o !== 1'b0) begin failures++; $display("FAIL mid_net_credit got %b want 0", net_credit_o); end
    checks++; if (rx_valid_o !== 1'b0 || tx_ready_o !== 1'b1) begin failures++; $display("FAIL mid_queues got rx%b tx%b want rx0 tx1", rx_valid_o, tx_ready_o); end
    checks++; if ({misroute_o, rx_overflow_o, credit_err_o} !== 3'b000) begin failures++; $display("FAIL mid_flags got %b want 000", {misroute_o, rx_overflow_o, credit_err_o}); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (net_credit_o !== 1'b0) begin failures++; $display("FAIL mid_no_pulse got %b want 0", net_credit_o); end
    rst = 1'b1;
    seen.delete();
    repeat (4) tick();
    checks++; if (seen.size() !== 0 || rx_valid_o !== 1'b0) begin failures++; $display("FAIL mid_discard got %0d/%b want 0/0", seen.size(), rx_valid_o); end
    net_credit_i = 1;
    tick();
    net_credit_i = 0;
    checks++; if (credit_err_o !== 1'b1) begin failures++; $display("FAIL mid_credit_full got %b want 1", credit_err_o); end
  endtask

  initial begin
    test_reset();
    test_basic_inject();
    test_credit_exhaust();
    test_tx_full();
    test_eject();
    test_simultaneous();
    test_errors();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
